// File: rtl/usr_shift_sequencer_if.sv
// ----------------------------------------------------------------------------
// usr_shift_sequencer_if
// Groups the job handshake and the shift-register command pins of
// usr_shift_sequencer.
//   in_valid/in_ready : job handshake (host -> sequencer)
//   in_data/in_dir/in_count : job fields (word, 0=right 1=left, shift count)
//   usr_ctrl/usr_data : commands to the shift register (00 hold, 01 right,
//                       10 left, 11 load)
//   busy/done         : status (done is a one-cycle pulse per finished job)
//   hold              : stall input, present only with USR_SEQ_HOLD_EN defined
// Modports: master = host side, slave = sequencer side.
// ----------------------------------------------------------------------------
interface usr_shift_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_dir;
  logic [CW-1:0]    in_count;
  logic [1:0]       usr_ctrl;
  logic [WIDTH-1:0] usr_data;
  logic             busy;
  logic             done;
`ifdef USR_SEQ_HOLD_EN
  logic             hold;
`endif

  modport master (
`ifdef USR_SEQ_HOLD_EN
    output hold,
`endif
    output in_valid, in_data, in_dir, in_count,
    input  in_ready, usr_ctrl, usr_data, busy, done
  );

  modport slave (
`ifdef USR_SEQ_HOLD_EN
    input  hold,
`endif
    input  in_valid, in_data, in_dir, in_count,
    output in_ready, usr_ctrl, usr_data, busy, done
  );
endinterface

// File: rtl/usr_shift_sequencer.sv
// ----------------------------------------------------------------------------
// usr_shift_sequencer
// Command sequencer for a universal shift register. Accepts a job
// {word, direction, shift count} over valid/ready, then drives the register
// with one LOAD cycle followed by N SHIFT cycles, and pulses done.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : usr_shift_sequencer_if.slave (handshake, job fields, register
//           commands, busy/done, optional hold)
// Optional feature macro: USR_SEQ_HOLD_EN adds the hold input, which stalls
// the job in LOAD/SHIFT (usr_ctrl forced to 00) and blocks acceptance in IDLE.
// Outputs are decoded from the registered state (plus hold when enabled).
// ----------------------------------------------------------------------------
module usr_shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input logic                  clk,
  input logic                  reset,
  usr_shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] WIDTH_CW = CW'(WIDTH);
  localparam logic [CW-1:0] ONE_CW   = CW'(1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             dir_reg, dir_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [CW-1:0]    remaining_reg, remaining_next;

  logic             hold_active;
  logic [CW-1:0]    count_clamped;
  logic             in_ready;
  logic [1:0]       usr_ctrl;
  logic             busy;
  logic             done;

`ifdef USR_SEQ_HOLD_EN
  assign hold_active = bus.hold;
`else
  assign hold_active = 1'b0;
`endif

  // Counts beyond the register width would only shift zeros in; clamp them
  // before capture so the job length is bounded by WIDTH shifts.
  assign count_clamped = (bus.in_count > WIDTH_CW) ? WIDTH_CW : bus.in_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      data_reg      <= '0;
      dir_reg       <= 1'b0;
      count_reg     <= '0;
      remaining_reg <= '0;
    end else begin
      state_reg     <= state_next;
      data_reg      <= data_next;
      dir_reg       <= dir_next;
      count_reg     <= count_next;
      remaining_reg <= remaining_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    data_next      = data_reg;
    dir_next       = dir_reg;
    count_next     = count_reg;
    remaining_next = remaining_reg;
    in_ready       = 1'b0;
    usr_ctrl       = 2'b00;
    busy           = 1'b1;
    done           = 1'b0;

    case (state_reg)
      IDLE: begin
        busy     = 1'b0;
        in_ready = !hold_active;
        if (bus.in_valid && !hold_active) begin
          data_next  = bus.in_data;
          dir_next   = bus.in_dir;
          count_next = count_clamped;
          state_next = LOAD;
        end
      end

      LOAD: begin
        if (!hold_active) begin
          usr_ctrl = 2'b11;
          if (count_reg == '0) begin
            state_next = DONE;
          end else begin
            remaining_next = count_reg;
            state_next     = SHIFT;
          end
        end
      end

      SHIFT: begin
        if (!hold_active) begin
          usr_ctrl = dir_reg ? 2'b10 : 2'b01;
          // remaining is at least 1 in SHIFT; the guard keeps it from
          // wrapping should the state ever be entered otherwise.
          if (remaining_reg != '0) begin
            remaining_next = remaining_reg - ONE_CW;
          end
          if (remaining_reg <= ONE_CW) begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.in_ready = in_ready;
  assign bus.usr_ctrl = usr_ctrl;
  assign bus.usr_data = data_reg;
  assign bus.busy     = busy;
  assign bus.done     = done;

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// ----------------------------------------------------------------------------
// tb_usr_shift_sequencer
// Directed bench for usr_shift_sequencer with a behavioural shift register
// (shift-in fill = 0) driven by the sequencer's usr_ctrl/usr_data.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// on the falling edge.
// ----------------------------------------------------------------------------
module tb_usr_shift_sequencer;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic clk;
  logic reset;
  logic [WIDTH-1:0] reg_out;

  int n_checks;
  int n_errors;

  usr_shift_sequencer_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  usr_shift_sequencer #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural universal shift register fed by the sequencer.
  always @(posedge clk) begin
    if (reset) begin
      reg_out <= '0;
    end else begin
      case (bus.usr_ctrl)
        2'b11:   reg_out <= bus.usr_data;
        2'b01:   reg_out <= {1'b0, reg_out[WIDTH-1:1]};
        2'b10:   reg_out <= {reg_out[WIDTH-2:0], 1'b0};
        default: reg_out <= reg_out;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one job starting from IDLE (called 1 unit after a rising edge).
  // Cycle k is the k-th cycle after the accept edge E0; done in cycle k means
  // it rose at edge E(k-1).
  task automatic run_job(input string tag, input logic [7:0] data, input logic dir,
                         input logic [CW-1:0] count, input int exp_shifts,
                         input int exp_done_edge, input logic [7:0] exp_out,
                         input int hold_start, input int hold_len);
    int shifts;
    int stalls;
    int ready_busy;
    int done_k;
    logic [1:0] shift_code;
    shift_code = dir ? 2'b10 : 2'b01;
    shifts = 0;
    stalls = 0;
    ready_busy = 0;
    done_k = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_dir   = dir;
    bus.in_count = count;
    @(posedge clk); #1;
    // Fields change while busy; the sequencer must ignore them.
    bus.in_valid = 1'b0;
    bus.in_data  = ~data;
    bus.in_dir   = ~dir;
    bus.in_count = '0;
    for (int k = 1; k <= 40 && done_k == 0; k++) begin
`ifdef USR_SEQ_HOLD_EN
      bus.hold = (k >= hold_start) && (k < hold_start + hold_len);
`endif
      @(negedge clk);
      if (k == 1) check({tag, "_load_ctrl"}, 32'(bus.usr_ctrl), 32'h3);
      if (bus.in_ready && bus.busy) ready_busy++;
      if (bus.usr_ctrl == shift_code) shifts++;
      else if (bus.busy && !bus.done && bus.usr_ctrl == 2'b00) stalls++;
      if (bus.done) begin
        done_k = k;
        check({tag, "_done_ctrl"}, 32'(bus.usr_ctrl), 32'h0);
        check({tag, "_done_ready"}, 32'(bus.in_ready), 32'h0);
        check({tag, "_out"}, 32'(reg_out), 32'(exp_out));
        check({tag, "_usr_data"}, 32'(bus.usr_data), 32'(data));
      end
      @(posedge clk); #1;
    end
`ifdef USR_SEQ_HOLD_EN
    bus.hold = 1'b0;
`endif
    check({tag, "_shifts"}, 32'(shifts), 32'(exp_shifts));
    check({tag, "_stalls"}, 32'(stalls), 32'(hold_len));
    check({tag, "_done_edge"}, 32'(done_k - 1), 32'(exp_done_edge));
    check({tag, "_ready_busy"}, 32'(ready_busy), 32'h0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.done), 32'h0);
    check({tag, "_ready_after"}, 32'(bus.in_ready), 32'h1);
    check({tag, "_busy_after"}, 32'(bus.busy), 32'h0);
    $display("job %s: data=%02h dir=%0d count=%0d shifts=%0d stalls=%0d done_edge=%0d out=%02h",
             tag, data, dir, count, shifts, stalls, done_k - 1, reg_out);
    @(posedge clk); #1;
  endtask

  // Back-to-back jobs with in_valid held high, reset during job 2's 3rd shift.
  task automatic run_reset_abort();
    logic [1:0] ctrl_log  [1:14];
    logic       ready_log [1:14];
    logic       busy_log  [1:14];
    logic       done_log  [1:14];
    logic [7:0] data_log  [1:14];
    logic [7:0] out_log   [1:14];
    int ready_busy;
    int late_done;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    bus.in_dir   = 1'b1;
    bus.in_count = CW'(3);
    @(posedge clk); #1;
    for (int k = 1; k <= 14; k++) begin
      if (k == 1) begin
        bus.in_data  = 8'h5A;
        bus.in_dir   = 1'b0;
        bus.in_count = CW'(5);
      end
      if (k == 10) reset = 1'b1;
      if (k == 11) begin
        reset = 1'b0;
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      ctrl_log[k]  = bus.usr_ctrl;
      ready_log[k] = bus.in_ready;
      busy_log[k]  = bus.busy;
      done_log[k]  = bus.done;
      data_log[k]  = bus.usr_data;
      out_log[k]   = reg_out;
      @(posedge clk); #1;
    end
    ready_busy = 0;
    for (int k = 1; k <= 5; k++) if (ready_log[k]) ready_busy++;
    late_done = 0;
    for (int k = 6; k <= 14; k++) if (done_log[k]) late_done++;
    check("b2b_job1_load", 32'(ctrl_log[1]), 32'h3);
    check("b2b_ready_busy", 32'(ready_busy), 32'h0);
    check("b2b_job1_done", 32'(done_log[5]), 32'h1);
    check("b2b_job1_out", 32'(out_log[5]), 32'hE0);
    check("b2b_idle_ready", 32'(ready_log[6]), 32'h1);
    check("b2b_job2_load", 32'(ctrl_log[7]), 32'h3);
    check("b2b_job2_data", 32'(data_log[7]), 32'h5A);
    check("b2b_job2_shift3", 32'(ctrl_log[10]), 32'h1);
    check("rst_ctrl", 32'(ctrl_log[11]), 32'h0);
    check("rst_busy", 32'(busy_log[11]), 32'h0);
    check("rst_ready", 32'(ready_log[11]), 32'h1);
    check("rst_usr_data", 32'(data_log[11]), 32'h0);
    check("rst_no_done", 32'(late_done), 32'h0);
    $display("job b2b_reset: job1 out=%02h job2 load at cycle 7, reset at cycle 10, ctrl after reset=%0d",
             out_log[5], ctrl_log[11]);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_dir   = 1'b0;
    bus.in_count = '0;
`ifdef USR_SEQ_HOLD_EN
    bus.hold = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state_ctrl", 32'(bus.usr_ctrl), 32'h0);
    check("rst_state_data", 32'(bus.usr_data), 32'h0);
    check("rst_state_ready", 32'(bus.in_ready), 32'h1);
    check("rst_state_busy", 32'(bus.busy), 32'h0);
    check("rst_state_done", 32'(bus.done), 32'h0);
    $display("reset: ctrl=%0d data=%02h ready=%0d busy=%0d done=%0d",
             bus.usr_ctrl, bus.usr_data, bus.in_ready, bus.busy, bus.done);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    //       tag     data   dir   count      shifts done_edge out    hold
    run_job("t1",   8'hAA, 1'b0, CW'(7),    7,     8,        8'h01, 0, 0);
    run_job("t2",   8'hFF, 1'b1, CW'(8),    8,     9,        8'h00, 0, 0);
    run_job("t3",   8'hF7, 1'b0, CW'(0),    0,     1,        8'hF7, 0, 0);
    run_job("t4",   8'h80, 1'b0, CW'(12),   8,     9,        8'h00, 0, 0);
    run_job("t4b",  8'h81, 1'b1, CW'(1),    1,     2,        8'h02, 0, 0);
    run_reset_abort();
    @(posedge clk); #1;

`ifdef USR_SEQ_HOLD_EN
    // Hold over the 4th shift cycle (cycle 5) for 3 cycles.
    run_job("t6",   8'hC3, 1'b0, CW'(6),    6,     10,       8'h03, 5, 3);
    bus.hold     = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h11;
    bus.in_count = CW'(1);
    @(negedge clk);
    check("hold_idle_ready", 32'(bus.in_ready), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("hold_idle_busy", 32'(bus.busy), 32'h0);
    $display("hold in idle: ready=%0d busy=%0d", bus.in_ready, bus.busy);
    @(posedge clk); #1;
    bus.hold     = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
